// File: rtl/vga_timing_monitor.sv
// Passive checker for the VGA sync/blank stream: recovers pixel and line counters,
// measures every line and frame against the mode, and reports lock and sticky errors.
module vga_timing_monitor #(
  parameter int H_ACTIVE    = 1024,
  parameter int H_TOTAL     = 1328,
  parameter int H_SYNC      = 136,
  parameter int V_ACTIVE    = 768,
  parameter int V_TOTAL     = 806,
  parameter int V_SYNC      = 6,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic        err_clr,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        locked,
  output logic        err,
  output logic [4:0]  err_code,
  output logic [10:0] meas_htotal,
  output logic [10:0] meas_vtotal,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {SEARCH, LOCKING, LOCKED} state_t;

  localparam int            CW     = $clog2(LOCK_FRAMES + 1);
  localparam logic [CW-1:0] LOCK_N = CW'(LOCK_FRAMES);

  function automatic logic [10:0] sat_inc(input logic [10:0] x);
    return (x == 11'h7FF) ? x : x + 11'd1;
  endfunction

  function automatic logic [10:0] sat_len(input logic [11:0] x);
    return x[11] ? 11'h7FF : x[10:0];
  endfunction

  state_t        state;
  logic          hsync_p0, vsync_p0, hblnk_p0, vblnk_p0;
  logic          hblnk_p1, vblnk_p1;
  logic [10:0]   act_cnt, hs_cnt;
  logic [10:0]   ln_cnt, vact_cnt, vs_cnt;
  logic          line_seen, frame_seen, v_pend, frame_err;
  logic [CW-1:0] clean_cnt;

  logic          hfall, vfall, line_chk, frame_chk, viol;
  logic [11:0]   len;
  logic [4:0]    new_err;
  logic [CW-1:0] clean_nxt;

  assign hfall     = hblnk_p1 & ~hblnk_p0;
  assign vfall     = vblnk_p1 & ~vblnk_p0;
  assign line_chk  = hfall & line_seen;
  assign frame_chk = vfall & frame_seen;
  assign len       = {1'b0, hcount_out} + 12'd1;

  // Line checks see the counts of the line just ended; frame checks exclude the
  // line starting on a coincident hblnk edge, which belongs to the new frame.
  assign new_err[0] = line_chk && (len != 12'(H_TOTAL));
  assign new_err[1] = line_chk && ((hs_cnt == 11'd0) || (hs_cnt != 11'(H_SYNC)));
  assign new_err[2] = line_chk && (act_cnt != 11'(H_ACTIVE));
  assign new_err[3] = frame_chk && (ln_cnt != 11'(V_TOTAL));
  assign new_err[4] = frame_chk && ((vact_cnt != 11'(V_ACTIVE)) || (vs_cnt != 11'(V_SYNC)));
  assign viol       = |new_err;
  assign clean_nxt  = clean_cnt + 1'b1;
  assign err        = |err_code;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      hsync_p0    <= 1'b0;
      vsync_p0    <= 1'b0;
      hblnk_p0    <= 1'b0;
      vblnk_p0    <= 1'b0;
      hblnk_p1    <= 1'b0;
      vblnk_p1    <= 1'b0;
      hcount_out  <= '0;
      vcount_out  <= '0;
      act_cnt     <= '0;
      hs_cnt      <= '0;
      ln_cnt      <= '0;
      vact_cnt    <= '0;
      vs_cnt      <= '0;
      meas_htotal <= '0;
      meas_vtotal <= '0;
      frame_cnt   <= '0;
      err_code    <= '0;
      line_seen   <= 1'b0;
      frame_seen  <= 1'b0;
      v_pend      <= 1'b0;
      frame_err   <= 1'b0;
      clean_cnt   <= '0;
      locked      <= 1'b0;
      state       <= SEARCH;
    end else begin
      // stage p0: register the raw stream
      hsync_p0 <= hsync_in;
      vsync_p0 <= vsync_in;
      hblnk_p0 <= hblnk_in;
      vblnk_p0 <= vblnk_in;
      // stage p1: edge history, counters and measurements
      hblnk_p1 <= hblnk_p0;
      vblnk_p1 <= vblnk_p0;

      if (hfall) begin
        hcount_out <= '0;
        act_cnt    <= 11'd1;
        hs_cnt     <= {10'd0, hsync_p0};
        line_seen  <= 1'b1;
        if (line_seen) meas_htotal <= sat_len(len);
        vcount_out <= (vfall || v_pend) ? 11'd0 : sat_inc(vcount_out);
        v_pend     <= 1'b0;
      end else begin
        hcount_out <= sat_inc(hcount_out);
        if (!hblnk_p0) act_cnt <= sat_inc(act_cnt);
        if (hsync_p0)  hs_cnt  <= sat_inc(hs_cnt);
        if (vfall)     v_pend  <= 1'b1;
      end

      if (vfall) begin
        ln_cnt     <= {10'd0, hfall};
        vact_cnt   <= {10'd0, hfall};
        vs_cnt     <= {10'd0, hfall & vsync_p0};
        frame_seen <= 1'b1;
        frame_cnt  <= frame_cnt + 16'd1;
        if (frame_seen) meas_vtotal <= ln_cnt;
      end else if (hfall) begin
        ln_cnt <= sat_inc(ln_cnt);
        if (!vblnk_p0) vact_cnt <= sat_inc(vact_cnt);
        if (vsync_p0)  vs_cnt   <= sat_inc(vs_cnt);
      end

      err_code <= (err_clr ? 5'd0 : err_code) | new_err;

      if (vfall)     frame_err <= 1'b0;
      else if (viol) frame_err <= 1'b1;

      case (state)
        SEARCH: begin
          if (vfall) begin
            state     <= LOCKING;
            clean_cnt <= '0;
          end
        end
        LOCKING: begin
          if (viol) begin
            clean_cnt <= '0;
          end else if (vfall && !frame_err) begin
            if (clean_nxt == LOCK_N) begin
              state     <= LOCKED;
              locked    <= 1'b1;
              clean_cnt <= '0;
            end else begin
              clean_cnt <= clean_nxt;
            end
          end
        end
        LOCKED: begin
          if (viol) begin
            state     <= LOCKING;
            locked    <= 1'b0;
            clean_cnt <= '0;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor on a scaled-down mode (24x12 total, 16x8 active).
module tb_vga_timing_monitor;

  localparam int HA  = 16;
  localparam int HT  = 24;
  localparam int HS  = 3;
  localparam int HFP = 2;
  localparam int VA  = 8;
  localparam int VT  = 12;
  localparam int VS  = 2;
  localparam int VFP = 1;
  localparam int FR  = HT * VT;

  logic        pclk = 1'b0;
  logic        rst;
  logic        hsync, vsync, hblnk, vblnk, err_clr;
  logic [10:0] hcount_out, vcount_out, meas_htotal, meas_vtotal;
  logic        locked, err;
  logic [4:0]  err_code;
  logic [15:0] frame_cnt;

  vga_timing_monitor #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC(HS), .V_ACTIVE(VA),
    .V_TOTAL(VT), .V_SYNC(VS), .LOCK_FRAMES(2)
  ) dut (
    .pclk(pclk), .rst(rst), .hsync_in(hsync), .vsync_in(vsync),
    .hblnk_in(hblnk), .vblnk_in(vblnk), .err_clr(err_clr),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .locked(locked),
    .err(err), .err_code(err_code), .meas_htotal(meas_htotal),
    .meas_vtotal(meas_vtotal), .frame_cnt(frame_cnt)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic hb;
    logic vb;
    int   eh;
    int   ev;
    int   efc;
  } vec_t;

  vec_t vecs[17];
  int   nchk = 0;
  int   nerr = 0;

  int   gh, gv, dh1, dv1, dh2, dv2, stretch_v;
  bit   cmp_en, stretch_req, vs_short;

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic addv(input int i, input logic hb, input logic vb,
                      input int eh, input int ev, input int efc);
    vecs[i] = '{hb, vb, eh, ev, efc};
  endtask

  // One generator cycle: compare 2-cycle-delayed counters, drive, advance.
  task automatic step();
    int vsw;
    @(negedge pclk);
    if (cmp_en && dh2 < HA && dv2 < VA) begin
      check("hcount_align", int'(hcount_out), dh2);
      check("vcount_align", int'(vcount_out), dv2);
    end
    vsw   = vs_short ? VS - 1 : VS;
    hblnk = (gh >= HA);
    hsync = (gh >= HA + HFP) && (gh < HA + HFP + HS);
    vblnk = (gv >= VA);
    vsync = (gv >= VA + VFP) && (gv < VA + VFP + vsw);
    dh2 = dh1; dv2 = dv1; dh1 = gh; dv1 = gv;
    if (stretch_req && gh == HT - 1 && gv == stretch_v) begin
      stretch_req = 1'b0;
    end else begin
      gh++;
      if (gh == HT) begin
        gh = 0;
        gv++;
        if (gv == VT) begin
          gv = 0;
          vs_short = 1'b0;
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic bit reached(input int what, input int target);
    case (what)
      0:       return frame_cnt == 16'(target);
      1:       return locked;
      2:       return err;
      default: return err_code[4];
    endcase
  endfunction

  task automatic wait_for(input string name, input int what, input int target, input int bound);
    int n = 0;
    while (!reached(what, target) && n < bound) begin
      step();
      n++;
    end
    if (!reached(what, target)) begin
      nchk++;
      nerr++;
      $display("FAIL %s: timeout after %0d cycles, frame_cnt=%0d required condition %0d", name, n, frame_cnt, target);
    end
  endtask

  task automatic drive_raw(input logic hb, input logic vb);
    @(negedge pclk);
    hsync = 1'b0; vsync = 1'b0; hblnk = hb; vblnk = vb;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hcount"}, int'(hcount_out), 0);
    check({tag, "_vcount"}, int'(vcount_out), 0);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_err_code"}, int'(err_code), 0);
    check({tag, "_meas_htotal"}, int'(meas_htotal), 0);
    check({tag, "_meas_vtotal"}, int'(meas_vtotal), 0);
    check({tag, "_frame_cnt"}, int'(frame_cnt), 0);
  endtask

  initial begin
    bit prev_locked;
    // {hblnk, vblnk} -> {hcount, vcount, frame_cnt} observed at the same negedge
    addv(0,  1, 1, 1, 0, 0);  addv(1,  0, 1, 2, 0, 0);  addv(2,  0, 1, 3, 0, 0);
    addv(3,  1, 1, 0, 1, 0);  addv(4,  1, 1, 1, 1, 0);  addv(5,  0, 0, 2, 1, 0);
    addv(6,  0, 0, 3, 1, 0);  addv(7,  1, 1, 0, 0, 1);  addv(8,  1, 1, 1, 0, 1);
    addv(9,  0, 1, 2, 0, 1);  addv(10, 0, 1, 3, 0, 1);  addv(11, 1, 0, 0, 1, 1);
    addv(12, 1, 0, 1, 1, 1);  addv(13, 0, 0, 2, 1, 2);  addv(14, 0, 0, 3, 1, 2);
    addv(15, 0, 0, 0, 0, 2);  addv(16, 0, 0, 1, 0, 2);

    rst = 1'b0; err_clr = 1'b0;
    hsync = 1'b0; vsync = 1'b0; hblnk = 1'b0; vblnk = 1'b0;
    cmp_en = 1'b0; stretch_req = 1'b0; vs_short = 1'b0; stretch_v = 0;
    dh1 = 9999; dv1 = 9999; dh2 = 9999; dv2 = 9999;
    repeat (3) @(negedge pclk);
    check_all_zero("reset");

    // Raw edge vectors: counter clear, coincident edges, vblnk ahead of hblnk
    hblnk = 1'b1; vblnk = 1'b1;
    @(negedge pclk);
    rst = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge pclk);
      check($sformatf("vec%0d_hcount", i), int'(hcount_out), vecs[i].eh);
      check($sformatf("vec%0d_vcount", i), int'(vcount_out), vecs[i].ev);
      check($sformatf("vec%0d_frame_cnt", i), int'(frame_cnt), vecs[i].efc);
      hblnk = vecs[i].hb;
      vblnk = vecs[i].vb;
    end

    // Horizontal counter saturation and saturated line length
    for (int i = 0; i < 2100; i++) drive_raw(1'b1, 1'b0);
    check("hcount_sat", int'(hcount_out), 2047);
    drive_raw(1'b0, 1'b0);
    drive_raw(1'b0, 1'b0);
    @(negedge pclk);
    check("hcount_clear_after_sat", int'(hcount_out), 0);
    check("meas_htotal_sat", int'(meas_htotal), 2047);

    // Golden stream from (0,0)
    rst = 1'b0;
    repeat (2) @(negedge pclk);
    gh = 0; gv = 0; dh1 = 9999; dv1 = 9999; dh2 = 9999; dv2 = 9999;
    step();
    rst = 1'b1;
    run(289);
    cmp_en = 1'b1;
    run(FR);
    cmp_en = 1'b0;
    run(FR);
    check("locked_before_3rd_vfall", int'(locked), 0);
    check("frame_cnt_before_3rd_vfall", int'(frame_cnt), 2);
    run(1);
    check("locked_after_2_clean", int'(locked), 1);
    check("frame_cnt_at_lock", int'(frame_cnt), 3);
    run(FR);
    check("golden_frame_cnt", int'(frame_cnt), 4);
    check("golden_locked", int'(locked), 1);
    check("golden_err", int'(err), 0);
    check("golden_err_code", int'(err_code), 0);
    check("golden_meas_htotal", int'(meas_htotal), HT);
    check("golden_meas_vtotal", int'(meas_vtotal), VT);

    // Stretch line 3 of the current frame by one blank cycle
    stretch_v = 3; stretch_req = 1'b1;
    prev_locked = locked;
    for (int n = 0; n < 2 * FR && !err; n++) begin
      prev_locked = locked;
      step();
    end
    check("stretch_err", int'(err), 1);
    check("stretch_meas_htotal", int'(meas_htotal), HT + 1);
    check("stretch_err_code", int'(err_code), 5'b00001);
    check("stretch_locked_before", int'(prev_locked), 1);
    check("stretch_locked_after", int'(locked), 0);
    wait_for("relock", 1, 1, 4 * FR);
    check("relock_frame_cnt", int'(frame_cnt), 7);
    check("relock_err_sticky", int'(err), 1);
    check("relock_err_code", int'(err_code), 5'b00001);

    // One frame with a short vsync
    vs_short = 1'b1;
    wait_for("vsync_short_detect", 3, 1, 2 * FR);
    check("vs_short_err_code", int'(err_code), 5'b10001);
    check("vs_short_frame_cnt", int'(frame_cnt), 8);
    check("vs_short_meas_vtotal", int'(meas_vtotal), VT);
    check("vs_short_locked", int'(locked), 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_err", int'(err), 0);
    check("clr_err_code", int'(err_code), 0);

    // Monitoring starts mid-frame
    rst = 1'b0;
    repeat (2) @(negedge pclk);
    gh = 10; gv = 5; vs_short = 1'b0;
    step();
    rst = 1'b1;
    wait_for("mid_first_vfall", 0, 1, 2 * FR);
    check("mid_err_code_first_frame", int'(err_code), 0);
    check("mid_locked_first_frame", int'(locked), 0);
    wait_for("mid_lock", 1, 1, 4 * FR);
    check("mid_lock_frame_cnt", int'(frame_cnt), 3);
    check("mid_lock_err_code", int'(err_code), 0);

    // Asynchronous reset mid-line while locked
    run(5);
    #2 rst = 1'b0;
    #1 check_all_zero("async_rst");
    step();
    rst = 1'b1;
    wait_for("rst_first_vfall", 0, 1, 2 * FR);
    check("rst_restart_locked1", int'(locked), 0);
    check("rst_restart_err", int'(err), 0);
    wait_for("rst_second_vfall", 0, 2, 2 * FR);
    check("rst_restart_locked2", int'(locked), 0);
    wait_for("rst_relock", 1, 1, 2 * FR);
    check("rst_relock_frame_cnt", int'(frame_cnt), 3);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
